// File: rtl/reg_enc_pkg.sv
// Shared types and constants for the register-select to index encoder.
// The popcount helper is only referenced when REG_ENC_COUNT_EN is defined.
package reg_enc_pkg;

  localparam int WIDTH = 16;
  localparam int IDXW  = 4;
  localparam int CNTW  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic [CNTW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNTW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNTW'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_index_encoder_lsb_index.sv
// Combinational lowest-set-bit finder over a select vector.
// one_left flags a vector with exactly one bit set; an all-zero vector gives idx 0, one_left 0.
module lsb_index #(
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             one_left
);

  // Scan from the top so the lowest set bit is the last writer.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDXW'(i);
      end
    end
  end

  assign one_left = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/reg_index_encoder.sv
// Streams the indices of a multi-hot 16-bit select vector, lowest set bit first.
// Optional macro REG_ENC_COUNT_EN adds out_count, the popcount of the accepted vector.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// in_ready and out_valid depend only on registered state, never on the other side's
// valid/ready, and out_idx/out_last hold steady while out_valid && !out_ready.
module reg_index_encoder
  import reg_enc_pkg::state_e;
  import reg_enc_pkg::IDLE;
  import reg_enc_pkg::EMIT;
`ifdef REG_ENC_COUNT_EN
  import reg_enc_pkg::popcount;
`endif
#(
  parameter int WIDTH = 16,
  parameter int IDXW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             zero_err
`ifdef REG_ENC_COUNT_EN
  ,
  output logic [4:0]       out_count
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_err_q, zero_err_d;
  logic [IDXW-1:0]  lsb_idx;
  logic             one_left;

  lsb_index #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_lsb_index (
    .vec      (pending_q),
    .idx      (lsb_idx),
    .one_left (one_left)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec == '0) begin
            zero_err_d = 1'b1;
          end else begin
            pending_d = in_vec;
            state_d   = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          // Clearing the lowest set bit retires exactly the index on out_idx.
          pending_d = pending_q & (pending_q - WIDTH'(1));
          if (one_left) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

`ifdef REG_ENC_COUNT_EN
  logic [4:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (state_q == IDLE && in_valid) begin
      count_d = popcount(in_vec);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_count = count_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_idx   = lsb_idx;
  assign out_last  = (state_q == EMIT) && one_left;
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_reg_index_encoder.sv
// Self-checking bench for reg_index_encoder: reset, table vectors, hand sequences
// for backpressure / zero vector / mid-burst reset, then random vectors against a queue model.
module tb_reg_index_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        zero_err;
`ifdef REG_ENC_COUNT_EN
  logic [4:0]  out_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  reg_index_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .zero_err  (zero_err)
`ifdef REG_ENC_COUNT_EN
    ,
    .out_count (out_count)
`endif
  );

  typedef struct {
    logic [15:0] vec;
    logic [3:0]  first_idx;
    logic [3:0]  last_idx;
    int          count;
  } vec_rec_t;

  vec_rec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the burst.
  task automatic run_vec(input logic [15:0] vec, input bit rand_ready,
                         output logic [3:0] first_idx, output logic [3:0] last_idx,
                         output int hs, output logic [15:0] recon);
    logic [3:0]  exp_q[$];
    logic [3:0]  e;
    logic [3:0]  prev_idx;
    bit          held;
    int          n_exp;
    int          cycles;
    for (int j = 0; j < 16; j++) begin
      if (vec[j]) exp_q.push_back(4'(j));
    end
    n_exp     = exp_q.size();
    first_idx = '0;
    last_idx  = '0;
    hs        = 0;
    recon     = '0;
    held      = 1'b0;
    prev_idx  = '0;
    cycles    = 0;
    check("accept_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_vec   = vec;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = 16'($urandom);
    while (exp_q.size() > 0 && cycles < 200) begin
      check("burst_out_valid", out_valid, 1);
      check("burst_in_ready", in_ready, 0);
      check("burst_out_last", out_last, exp_q.size() == 1);
`ifdef REG_ENC_COUNT_EN
      check("burst_out_count", out_count, n_exp);
`endif
      if (held) check("hold_out_idx", out_idx, prev_idx);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready) begin
        e = exp_q.pop_front();
        check("out_idx_order", out_idx, e);
        if (hs == 0) first_idx = out_idx;
        last_idx = out_idx;
        hs++;
        recon = recon | (16'(1) << out_idx);
        held = 1'b0;
      end else begin
        held     = 1'b1;
        prev_idx = out_idx;
      end
      @(negedge clk);
      cycles++;
    end
    check("burst_timeout_left", exp_q.size(), 0);
    check("after_burst_in_ready", in_ready, 1);
    check("after_burst_out_valid", out_valid, 0);
    check("after_burst_out_last", out_last, 0);
    check("burst_handshakes", hs, n_exp);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0]  f_idx, l_idx;
    logic [15:0] rec;
    logic [15:0] rv;
    int          hs;

    tbl[0] = '{16'h0001, 4'd0,  4'd0,  1};
    tbl[1] = '{16'h8421, 4'd0,  4'd15, 4};
    tbl[2] = '{16'h8000, 4'd15, 4'd15, 1};
    tbl[3] = '{16'hFFFF, 4'd0,  4'd15, 16};
    tbl[4] = '{16'hA5A5, 4'd0,  4'd15, 8};
    tbl[5] = '{16'h0180, 4'd7,  4'd8,  2};

    do_reset();
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_idx", out_idx, 0);
    check("reset_out_last", out_last, 0);
    check("reset_zero_err", zero_err, 0);
`ifdef REG_ENC_COUNT_EN
    check("reset_out_count", out_count, 0);
`endif

    // Table vectors with out_ready held high; recon is the round-trip decode.
    for (int t = 0; t < 6; t++) begin
      run_vec(tbl[t].vec, 1'b0, f_idx, l_idx, hs, rec);
      check("tbl_first_idx", f_idx, tbl[t].first_idx);
      check("tbl_last_idx", l_idx, tbl[t].last_idx);
      check("tbl_count", hs, tbl[t].count);
      check("tbl_round_trip", rec, tbl[t].vec);
    end

    // Backpressure: index 1 holds for three stalled cycles.
    in_valid = 1'b1;
    in_vec   = 16'h0006;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_hold_idx", out_idx, 1);
      check("bp_hold_last", out_last, 0);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("bp_idx_first", out_idx, 1);
    @(negedge clk);
    check("bp_idx_second", out_idx, 2);
    check("bp_last_second", out_last, 1);
    check("bp_in_ready_last", in_ready, 0);
    @(negedge clk);
    check("bp_in_ready_after", in_ready, 1);
    check("bp_out_valid_after", out_valid, 0);
    out_ready = 1'b0;

    // Zero vector: one-cycle zero_err, no output.
    check("zero_err_before", zero_err, 0);
    in_valid = 1'b1;
    in_vec   = 16'h0000;
    @(negedge clk);
    in_valid = 1'b0;
    check("zero_err_pulse", zero_err, 1);
    check("zero_out_valid", out_valid, 0);
    check("zero_in_ready", in_ready, 1);
`ifdef REG_ENC_COUNT_EN
    check("zero_out_count", out_count, 0);
`endif
    @(negedge clk);
    check("zero_err_cleared", zero_err, 0);
    check("zero_out_valid_2", out_valid, 0);

    // Reset in the middle of an all-ones burst.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_burst_idx", out_idx, k);
      @(negedge clk);
    end
    check("rst_burst_idx3", out_idx, 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_last", out_last, 0);
    check("rst_mid_out_idx", out_idx, 0);
`ifdef REG_ENC_COUNT_EN
    check("rst_mid_out_count", out_count, 0);
`endif
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_idle_valid", out_valid, 0);

    // Random vectors with random backpressure against the queue model.
    for (int r = 0; r < 40; r++) begin
      rv = 16'($urandom_range(1, 65535));
      run_vec(rv, 1'b1, f_idx, l_idx, hs, rec);
      check("rand_round_trip", rec, rv);
      check("rand_count", hs, $countones(rv));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reg_index_encoder.md
# reg_index_encoder

- Converts a one-hot or multi-hot 16-bit register-select vector into a stream of 4-bit register indices, lowest set bit first.
- Reverse of the 4-to-16 register-select decoder; used wherever the datapath produces an enable vector and a register index is needed.
- Example users: multi-register save/restore sequencing, bus-source index generation for trace/debug.
- Valid/ready on both sides; one index per cycle while the output is ready.

## Interface
Parameters:
- WIDTH, 16, input vector width; fixed at 16 for this revision.
- IDXW, 4, index width, equal to log2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block accepts a vector this cycle.
- in_vec  input  WIDTH  register-select vector; any number of bits may be set.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer takes out_idx this cycle.
- out_idx  output  IDXW  index of the lowest pending set bit.
- out_last  output  1  out_idx is the final index of the current vector.
- zero_err  output  1  one-cycle pulse; an all-zero vector was accepted.

## Operation
- **States:** IDLE, EMIT. Registers: state, pending[15:0], zero_err.
- **IDLE:**
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready with in_vec!=0: pending<=in_vec; go to EMIT.
  - On in_valid&&in_ready with in_vec==0: stay in IDLE; zero_err=1 on the next cycle only; no output is produced.
- **EMIT:**
  - in_ready=0, out_valid=1.
  - out_idx = position of the lowest set bit of pending.
  - out_last = 1 when pending has exactly one bit set.
  - On out_valid&&out_ready: clear that bit in pending. If out_last, go to IDLE; otherwise stay in EMIT.
- **Output hold:** out_idx and out_last stay stable while out_valid && !out_ready.
- **Output timing:** all outputs are decoded from registers. No combinational path from in_* to out_*, or from out_ready to in_ready.
- **Reset:**
  - Reset values: state=IDLE, pending=0, zero_err=0.
  - Output reset values: out_valid=0, out_idx=0, out_last=0, in_ready=1 (state IDLE).
  - Reset during EMIT discards the remaining pending bits. The next cycle is IDLE with in_ready=1.
- **Bit 15:** out_idx=15 is a valid value; index arithmetic does not wrap.

## Timing
- **Latency:** vector accepted at edge N → out_valid high from cycle N+1, presenting the first index.
- **Throughput:**
  - A vector with k set bits occupies EMIT for k cycles when out_ready is held high.
  - in_ready rises one cycle after the last handshake.
  - Total for one vector: k+1 cycles, including the accept cycle.
- **No bypass:** the next vector is never accepted in the same cycle as the out_last handshake.
- **zero_err:** high exactly one cycle, in cycle N+1.

## Configuration
- Macro: REG_ENC_COUNT_EN.
- **Defined:**
  - Adds output port out_count[4:0], the popcount of the accepted vector (0–16).
  - Registered at accept and held constant through the entire EMIT burst.
  - Reset value 0. An all-zero accept loads 0.
- **Undefined:** port and popcount logic are absent; all other behaviour is identical.

## Structure
- **Package reg_enc_pkg:**
  - state enum typedef {IDLE, EMIT}.
  - Constants WIDTH=16 and IDXW=4.
- **Sub-module lsb_index:** combinational, 16-bit vector → 4-bit lowest-set-bit index plus a one_left flag. It is instantiated once on pending.

## Test plan
- **Single bit:** reset, then in_vec=16'h0001 with out_ready=1 → out_idx=0, out_last=1 in cycle N+1; in_ready=1 in cycle N+2.
- **Multi-hot order:** in_vec=16'h8421, out_ready=1 → out_idx sequence 0, 5, 10, 15 on consecutive cycles; out_last only on 15; out_count=4 when REG_ENC_COUNT_EN is defined.
- **Backpressure:** in_vec=16'h0006, out_ready low 3 cycles → out_idx held at 1; then out_ready=1 → idx 1 then 2; in_ready stays 0 until after idx 2.
- **Zero vector:** in_vec=0 accepted → zero_err pulses once in the next cycle; out_valid stays 0; in_ready stays 1.
- **Reset mid-burst:** in_vec=16'hFFFF, rst_n=0 after 3 indices → next cycle out_valid=0, in_ready=1, out_last=0.
- **Round trip:** in_vec=16'hA5A5, each emitted index fed through the 4-to-16 decoder and ORed → result equals 16'hA5A5.
